fifo_uart_tx: RTL

Downstream consumer of the FIFO block. It drains the FIFO one word at a time through the FIFO's pop interface and serialises each word as an 8N1-style asynchronous frame on a single TX line: start bit, WORDLENGHT data bits LSB first, one stop bit. The block sits between the FIFO's data_out/empty_out outputs and the board pin.

---
 rtl/fifo_uart_tx_pkg.sv | 30 +++
 rtl/fifo_uart_tx_bit_timer.sv | 37 +++
 rtl/fifo_uart_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_uart_tx_pkg                                                   |
// | Shared types and helpers for the FIFO-fed UART transmitter.        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Cycles waited after the pop decision so the FIFO's registered read settles.
  localparam int SETTLE_CYCLES = 2;

  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_uart_tx_bit_timer                                             |
// | Free-running bit-period counter: tick every CLK_PER_BIT cycles.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fifo_uart_tx_bit_timer
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int c_cnt_w = CeilLog2(CLK_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // First tick lands CLK_PER_BIT cycles after the edge that last saw clear.
  assign tick = !clear && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_uart_tx                                                       |
// | Pops words from the FIFO and sends them as start/data/stop frames. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WORDLENGHT  = 8,
  parameter int CLK_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_clear,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [WORDLENGHT-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int c_idx_w = (CeilLog2(WORDLENGHT) < 1) ? 1 : CeilLog2(WORDLENGHT);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDLENGHT - 1);
  localparam int c_set_w = CeilLog2(SETTLE_CYCLES + 1);
  localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE_CYCLES);

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [c_set_w-1:0]    r_settle_cnt;
  logic [c_set_w-1:0]    w_settle_next;
  logic [c_idx_w-1:0]    r_bit_idx;
  logic [c_idx_w-1:0]    w_idx_next;
  logic [c_idx_w-1:0]    w_idx_inc;
  logic [WORDLENGHT-1:0] r_shift;
  logic [WORDLENGHT-1:0] w_shift_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  r_pop;
  logic                  w_pop_next;
  logic                  w_tick;
  logic                  w_timer_clear;

  // Timer is held cleared until START entry so the start bit gets a full period.
  assign w_timer_clear = sync_clear || (r_state == IDLE) || (r_state == SETTLE);
  assign w_idx_inc     = r_bit_idx + 1'b1;

  fifo_uart_tx_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(w_timer_clear),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_pop        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
      r_bit_idx    <= w_idx_next;
      r_shift      <= w_shift_next;
      r_tx         <= w_tx_next;
      r_pop        <= w_pop_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_idx_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    w_pop_next    = 1'b0;
    if (sync_clear) begin
      w_state_next  = IDLE;
      w_settle_next = '0;
      w_idx_next    = '0;
      w_tx_next     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_tx_next = 1'b1;
          if (enable && !fifo_empty) begin
            w_state_next  = SETTLE;
            w_settle_next = '0;
          end
        end
        SETTLE: begin
          if (r_settle_cnt == c_settle_last) begin
            w_state_next = START;
            w_shift_next = fifo_data;
            w_pop_next   = 1'b1;
            w_tx_next    = 1'b0;
          end else begin
            w_settle_next = r_settle_cnt + 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            w_state_next = DATA;
            w_idx_next   = '0;
            w_tx_next    = r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == c_last_idx) begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end else begin
              w_idx_next = w_idx_inc;
              w_tx_next  = r_shift[w_idx_inc];
            end
          end
        end
        STOP: begin
          if (w_tick) w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
          w_tx_next    = 1'b1;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign fifo_pop   = r_pop;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_tick;

endmodule
`default_nettype wire
